cla_pipe: RTL and testbench
===========================

CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand width; SHALL be a multiple of 16 in 16..256.
REQ-002 Parameter LATENCY, default 2, register stages from input acceptance to output; SHALL be 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 din1  input  WIDTH  operand A.
REQ-008 din2  input  WIDTH  operand B.
REQ-009 cin  input  1  carry in; ignored when sub=1.
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 dout  output  WIDTH  sum/difference.
REQ-014 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-015 ovf  output  1  signed overflow of the operation.

Function
REQ-016 Adder SHALL be WIDTH/16 groups of 16-bit CLA; group P/G combined by a second lookahead level in sets of 4, a third level when WIDTH > 64; no ripple carry between groups.
REQ-017 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-018 Transfer in occurs when in_valid && in_ready; out when out_valid && out_ready.
REQ-019 Pipeline SHALL advance as a unit: advance = !out_valid || out_ready; in_ready = advance.
REQ-020 With out_ready held 1, result of beat accepted in cycle N SHALL appear with out_valid=1 in cycle N+LATENCY; throughput one beat per cycle.
REQ-021 When out_valid && !out_ready, all stages, dout, cout, ovf SHALL hold unchanged and in_ready SHALL be 0.
REQ-022 Each stage SHALL carry a valid bit; bubbles (in_valid=0 while advancing) propagate as invalid and SHALL collapse behind a stalled head beat.
REQ-023 Results SHALL leave in acceptance order; no beat dropped or duplicated.
REQ-024 LATENCY=1: lookahead fully combinational before the single register; LATENCY>=2: group P/G/sums registered in stage 1, upper lookahead and carry-select of group sums in later stages.

Reset
REQ-025 With rst=1 at an edge, all stage valid bits, out_valid, dout, cout, ovf SHALL become 0 on that edge.
REQ-026 Reset mid-stream SHALL discard all in-flight beats; in_ready SHALL be 1 the cycle after reset releases.
REQ-027 in_valid during reset SHALL NOT be accepted.

Configuration
REQ-028 Macro CLA_PIPE_SAT_EN defined: on signed overflow dout SHALL saturate to 0x7F..F (positive overflow) or 0x80..0 (negative overflow); ovf still reports the event.
REQ-029 CLA_PIPE_SAT_EN undefined: dout SHALL be the wrapped modulo-2^WIDTH result; no saturation logic present.

Structure
REQ-030 Shared package cla_pkg SHALL hold CLA_GROUP_W=16, CLA_FANIN=4, the saturation constants function, and typedef pg_t (struct of propagate, generate).
REQ-031 Sub-module cla_pipe_stage (one payload+valid register with hold enable) SHALL be instantiated LATENCY times.

Verification
REQ-032 WIDTH=64, LATENCY=2: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1, sub=0 accepted cycle 0 -> cycle 2 dout=0, cout=1, ovf=0.
REQ-033 A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> ovf=1; dout=0x8000_0000_0000_0000 without macro, 0x7FFF_FFFF_FFFF_FFFF with CLA_PIPE_SAT_EN.
REQ-034 sub=1, A=5, B=7 -> dout=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-035 Back-to-back 8 beats, out_ready low cycles 4..6 -> in_ready=0 and outputs frozen those cycles; all 8 results in order, none lost.
REQ-036 rst asserted 1 cycle with 2 beats in flight -> next cycle out_valid=0, those beats never emitted.
REQ-037 Random 10^5 beats, WIDTH in {16,64,128}, LATENCY in {1,4}, random valid/ready -> every result matches reference model A±B.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, P/G type and lookahead helpers for cla_pipe
package cla_pkg;

   localparam int CLA_GROUP_W = 16;
   localparam int CLA_FANIN   = 4;
   localparam int CLA_MAX_W   = 256;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   // Largest positive (neg=0) or most negative (neg=1) value of a width-bit signed number
   function automatic logic [CLA_MAX_W-1:0] sat_value(input int width, input logic neg);
      logic [CLA_MAX_W-1:0] msb;
      msb = CLA_MAX_W'(1) << (width - 1);
      return neg ? msb : msb - CLA_MAX_W'(1);
   endfunction

   // Carries into positions 0..3 of a 4-wide lookahead block
   function automatic logic [3:0] la_carry(input logic [2:0] p, input logic [2:0] g, input logic c);
      logic [3:0] r;
      r[0] = c;
      r[1] = g[0] | (p[0] & c);
      r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      return r;
   endfunction

   // Block propagate/generate of a 4-wide lookahead block
   function automatic pg_t la_pg(input logic [3:0] p, input logic [3:0] g);
      pg_t r;
      r.p = &p;
      r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      return r;
   endfunction

   // 16-bit two-level CLA: returns {G, P, sum with carry-in 1, sum with carry-in 0}
   function automatic logic [2*CLA_GROUP_W+1:0] cla16(input logic [CLA_GROUP_W-1:0] a,
                                                      input logic [CLA_GROUP_W-1:0] b);
      logic [CLA_GROUP_W-1:0] p, g, cy0, cy1;
      logic [3:0] np, ng, nc0, nc1;
      pg_t t;
      pg_t gpg;
      p = a ^ b;
      g = a & b;
      for (int n = 0; n < 4; n++) begin
         t = la_pg(p[4*n +: 4], g[4*n +: 4]);
         np[n] = t.p;
         ng[n] = t.g;
      end
      nc0 = la_carry(np[2:0], ng[2:0], 1'b0);
      nc1 = la_carry(np[2:0], ng[2:0], 1'b1);
      for (int n = 0; n < 4; n++) begin
         cy0[4*n +: 4] = la_carry(p[4*n +: 3], g[4*n +: 3], nc0[n]);
         cy1[4*n +: 4] = la_carry(p[4*n +: 3], g[4*n +: 3], nc1[n]);
      end
      gpg = la_pg(np, ng);
      return {gpg.g, gpg.p, p ^ cy1, p ^ cy0};
   endfunction

endpackage

// File: rtl/cla_pipe_stage.sv
// rtl/cla_pipe_stage.sv - one payload + valid pipeline register with hold enable
module cla_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         d_valid,
   input  logic [W-1:0] d,
   output logic         q_valid,
   output logic [W-1:0] q
);

   // Load when the pipeline advances, hold otherwise; reset clears valid and payload
   always_ff @(posedge clk) begin
      if (rst) begin
         q_valid <= 1'b0;
         q       <= '0;
      end else if (en) begin
         q_valid <= d_valid;
         q       <= d;
      end
   end

endmodule

// File: rtl/cla_pipe.sv
// rtl/cla_pipe.sv - pipelined hierarchical CLA add/sub; optional saturation via CLA_PIPE_SAT_EN
module cla_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din1,
   input  logic [WIDTH-1:0] din2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             cout,
   output logic             ovf
);

   localparam int NG  = WIDTH / CLA_GROUP_W;
   localparam int NS  = (NG + CLA_FANIN - 1) / CLA_FANIN;
   localparam int NGP = NS * CLA_FANIN;
   localparam int P1  = 2 * WIDTH + 2 * NG + 3;
   localparam int PF  = WIDTH + 2;
   localparam int NF  = (LATENCY == 1) ? 1 : LATENCY - 1;

   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   logic [WIDTH-1:0] bx, s1_sum0, s1_sum1;
   logic [NG-1:0]    s1_p, s1_g;
   logic             cin_eff;
   logic [P1-1:0]    s1_d;

   // Operand conditioning, per-group carry-select sums and group P/G
   always_comb begin
      logic [2*CLA_GROUP_W+1:0] grp;
      grp      = '0;
      s1_sum0  = '0;
      s1_sum1  = '0;
      s1_p     = '0;
      s1_g     = '0;
      bx       = sub ? ~din2 : din2;
      cin_eff  = sub ? 1'b1 : cin;
      for (int k = 0; k < NG; k++) begin
         grp = cla16(din1[k*CLA_GROUP_W +: CLA_GROUP_W], bx[k*CLA_GROUP_W +: CLA_GROUP_W]);
         s1_sum0[k*CLA_GROUP_W +: CLA_GROUP_W] = grp[CLA_GROUP_W-1:0];
         s1_sum1[k*CLA_GROUP_W +: CLA_GROUP_W] = grp[2*CLA_GROUP_W-1:CLA_GROUP_W];
         s1_p[k] = grp[2*CLA_GROUP_W];
         s1_g[k] = grp[2*CLA_GROUP_W+1];
      end
      s1_d = {bx[WIDTH-1], din1[WIDTH-1], cin_eff, s1_g, s1_p, s1_sum1, s1_sum0};
   end

   logic [P1-1:0] up;
   logic          up_valid;

   generate
      if (LATENCY == 1) begin : g_comb
         assign up       = s1_d;
         assign up_valid = in_valid;
      end else begin : g_reg
         cla_pipe_stage #(.W(P1)) u_s1 (
            .clk(clk), .rst(rst), .en(advance),
            .d_valid(in_valid), .d(s1_d),
            .q_valid(up_valid), .q(up)
         );
      end
   endgenerate

   logic [WIDTH-1:0] up_sum0, up_sum1;
   logic [NG-1:0]    up_p, up_g;
   logic             up_cin, up_am, up_bm;
   assign up_sum0 = up[WIDTH-1:0];
   assign up_sum1 = up[2*WIDTH-1:WIDTH];
   assign up_p    = up[2*WIDTH+NG-1:2*WIDTH];
   assign up_g    = up[2*WIDTH+2*NG-1:2*WIDTH+NG];
   assign up_cin  = up[2*WIDTH+2*NG];
   assign up_am   = up[P1-2];
   assign up_bm   = up[P1-1];

   logic [NGP-1:0] gpp, ggp, gc;
   logic [NS-1:0]  set_cin;

   // Pad group P/G to whole sets; padding passes carries through untouched
   always_comb begin
      gpp = '1;
      ggp = '0;
      gpp[NG-1:0] = up_p;
      ggp[NG-1:0] = up_g;
   end

   generate
      if (NS > 1) begin : g_lvl3
         logic [CLA_FANIN-1:0] sp, sg;
         logic [3:0]           tc;
         // Third lookahead level over sets of four groups
         always_comb begin
            pg_t t;
            sp = '1;
            sg = '0;
            for (int s = 0; s < NS; s++) begin
               t = la_pg(gpp[CLA_FANIN*s +: CLA_FANIN], ggp[CLA_FANIN*s +: CLA_FANIN]);
               sp[s] = t.p;
               sg[s] = t.g;
            end
            tc = la_carry(sp[2:0], sg[2:0], up_cin);
         end
         assign set_cin = tc[NS-1:0];
      end else begin : g_lvl2
         assign set_cin = up_cin;
      end
   endgenerate

   // Second lookahead level: carry into every group from its set carry-in
   always_comb begin
      gc = '0;
      for (int s = 0; s < NS; s++)
         gc[CLA_FANIN*s +: CLA_FANIN] = la_carry(gpp[CLA_FANIN*s +: 3], ggp[CLA_FANIN*s +: 3], set_cin[s]);
   end

`ifdef CLA_PIPE_SAT_EN
   logic [CLA_MAX_W-1:0] sat_full;
   assign sat_full = sat_value(WIDTH, up_am);
`endif

   logic [WIDTH-1:0] res;
   logic             c_out, c_msb, v;
   logic [PF-1:0]    fin;

   // Carry-select of group sums, carry out and signed overflow
   always_comb begin
      res = '0;
      for (int k = 0; k < NG; k++)
         res[k*CLA_GROUP_W +: CLA_GROUP_W] = gc[k] ? up_sum1[k*CLA_GROUP_W +: CLA_GROUP_W]
                                                   : up_sum0[k*CLA_GROUP_W +: CLA_GROUP_W];
      c_out = ggp[NG-1] | (gpp[NG-1] & gc[NG-1]);
      c_msb = up_am ^ up_bm ^ res[WIDTH-1];
      v     = c_msb ^ c_out;
`ifdef CLA_PIPE_SAT_EN
      if (v)
         res = sat_full[WIDTH-1:0];
`endif
      fin = {v, c_out, res};
   end

   logic [PF-1:0] f_dat [NF+1];
   logic          f_vld [NF+1];
   assign f_dat[0] = fin;
   assign f_vld[0] = up_valid;

   generate
      for (genvar i = 0; i < NF; i++) begin : g_fin
         cla_pipe_stage #(.W(PF)) u_f (
            .clk(clk), .rst(rst), .en(advance),
            .d_valid(f_vld[i]), .d(f_dat[i]),
            .q_valid(f_vld[i+1]), .q(f_dat[i+1])
         );
      end
   endgenerate

   assign out_valid = f_vld[NF];
   assign dout      = f_dat[NF][WIDTH-1:0];
   assign cout      = f_dat[NF][WIDTH];
   assign ovf       = f_dat[NF][WIDTH+1];

endmodule

// File: tb/tb_cla_pipe.sv
// tb/tb_cla_pipe.sv - directed self-checking bench for cla_pipe (WIDTH=64, LATENCY=2)
module tb_cla_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [63:0] din1, din2, dout;

   int n_assert = 0;
   int n_fail   = 0;
   int sent, recv;

   logic [63:0] va [8];
   logic [63:0] vb [8];
   logic        vc [8];
   logic        vs [8];
   logic [65:0] held;
   logic        was_stall;
   logic [65:0] sb [$];
   logic [65:0] exp_v;

`ifdef CLA_PIPE_SAT_EN
   localparam logic [63:0] E2 = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] E5 = 64'h8000_0000_0000_0000;
   localparam logic [63:0] E9 = 64'h8000_0000_0000_0000;
`else
   localparam logic [63:0] E2 = 64'h8000_0000_0000_0000;
   localparam logic [63:0] E5 = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] E9 = 64'h0000_0000_0000_0000;
`endif

   cla_pipe #(.WIDTH(64), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .din1(din1), .din2(din2), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic c, input logic s);
      logic [63:0] bb;
      logic [64:0] r;
      logic [63:0] d;
      logic        o;
      bb = s ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {64'd0, (s ? 1'b1 : c)};
      o  = (a[63] == bb[63]) && (r[63] != a[63]);
      d  = r[63:0];
`ifdef CLA_PIPE_SAT_EN
      if (o) d = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
      return {o, r[64], d};
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed {ovf,cout,dout}=%h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic s, input logic [65:0] exp);
      din1 = a; din2 = b; cin = c; sub = s;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk1({tag, "_early"}, out_valid, 1'b0);
      tick();
      chk1({tag, "_valid"}, out_valid, 1'b1);
      chkw(tag, {ovf, cout, dout}, exp);
      tick();
      chk1({tag, "_gone"}, out_valid, 1'b0);
   endtask

   initial begin
      // reset with a beat offered: it must not be taken
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      din1 = 64'h1234; din2 = 64'h1; cin = 1'b0; sub = 1'b0;
      tick();
      tick();
      chk1("rst_out_valid", out_valid, 1'b0);
      chkw("rst_outputs", {ovf, cout, dout}, 66'd0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk1("rst_in_ready", in_ready, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk1("rst_no_accept", out_valid, 1'b0);
      end

      // directed vectors
      run_one("all1_plus_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, {1'b0, 1'b1, 64'h0});
      run_one("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, {1'b1, 1'b0, E2});
      run_one("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      run_one("sub_7_5", 64'd7, 64'd5, 1'b0, 1'b1, {1'b0, 1'b1, 64'd2});
      run_one("neg_ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, {1'b1, 1'b1, E5});
      run_one("grp_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {1'b0, 1'b0, 64'h0000_0001_0000_0000});
      run_one("prop_no_cin", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0,
              {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
      run_one("prop_cin", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0,
              {1'b0, 1'b1, 64'h0});
      run_one("sub_ign_cin", 64'd10, 64'd3, 1'b1, 1'b1, {1'b0, 1'b1, 64'd7});
      run_one("neg_ovf_add", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
              {1'b1, 1'b1, E9});

      // back-to-back 8 beats with out_ready low in cycles 4..6
      for (int i = 0; i < 8; i++) begin
         va[i] = {$urandom, $urandom};
         vb[i] = {$urandom, $urandom};
         vc[i] = 1'($urandom_range(0, 1));
         vs[i] = 1'($urandom_range(0, 1));
      end
      va[3] = 64'h7FFF_FFFF_FFFF_FFFF; vb[3] = 64'd1; vc[3] = 1'b0; vs[3] = 1'b0;
      sent = 0; recv = 0; was_stall = 1'b0; held = '0;
      for (int k = 0; k < 30 && recv < 8; k++) begin
         out_ready = !(k >= 4 && k <= 6);
         in_valid  = (sent < 8);
         if (sent < 8) begin
            din1 = va[sent]; din2 = vb[sent]; cin = vc[sent]; sub = vs[sent];
         end
         #1;
         if (k == 4) chk1("stall_head_valid", out_valid, 1'b1);
         if (out_valid && !out_ready) begin
            chk1("stall_in_ready", in_ready, 1'b0);
            if (was_stall) chkw("stall_hold", {ovf, cout, dout}, held);
         end
         was_stall = out_valid && !out_ready;
         held      = {ovf, cout, dout};
         if (out_valid && out_ready) begin
            chkw("stall_order", {ovf, cout, dout}, model(va[recv], vb[recv], vc[recv], vs[recv]));
            recv++;
         end
         if (in_valid && in_ready) sent++;
         tick();
      end
      chkn("stall_count", recv, 8);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();

      // reset with two beats in flight
      out_ready = 1'b0; in_valid = 1'b1;
      din1 = 64'd100; din2 = 64'd1; cin = 1'b0; sub = 1'b0;
      tick();
      din1 = 64'd200;
      tick();
      chk1("flight_head_valid", out_valid, 1'b1);
      in_valid = 1'b0; rst = 1'b1;
      tick();
      chk1("flight_rst_valid", out_valid, 1'b0);
      rst = 1'b0; out_ready = 1'b1;
      #1;
      chk1("flight_in_ready", in_ready, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk1("flight_discarded", out_valid, 1'b0);
      end

      // random valid/ready traffic against the reference model
      sb.delete();
      for (int k = 0; k < 600; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            0:       din1 = 64'hFFFF_FFFF_FFFF_FFFF;
            1:       din1 = 64'h8000_0000_0000_0000;
            default: din1 = {$urandom, $urandom};
         endcase
         din2 = ($urandom_range(0, 7) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
         cin  = 1'($urandom_range(0, 1));
         sub  = 1'($urandom_range(0, 1));
         #1;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk1("rnd_extra", out_valid, 1'b0);
            else begin
               exp_v = sb.pop_front();
               chkw("rnd_result", {ovf, cout, dout}, exp_v);
            end
         end
         if (in_valid && in_ready) sb.push_back(model(din1, din2, cin, sub));
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20 && sb.size() > 0; k++) begin
         #1;
         if (out_valid) begin
            exp_v = sb.pop_front();
            chkw("rnd_drain_result", {ovf, cout, dout}, exp_v);
         end
         tick();
      end
      chkn("rnd_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
